// File: rtl/lcd_init_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_init_ctrl
//
// Power-on initialisation sequencer for an 8080-style parallel LCD panel.
// After a start pulse it pulses the panel hardware reset and waits for the
// panel to come up. It then streams every word of an external init ROM
// (addresses 0..LAST_ADDR) onto the 8080 bus as one write strobe per word.
// A long pause is inserted after the sleep-out command. Chip select stays
// asserted after the last command (memory write) so the pixel path can take
// over the bus directly.
//
// Ports
//   clk        in   1  single clock, all logic on posedge
//   rst_n      in   1  synchronous active-low reset
//   start      in   1  single-cycle launch pulse (honoured only in IDLE/DONE)
//   rom_addr   out  7  init ROM address
//   rom_data   in   9  {DCX, DATA}, valid one cycle after rom_addr
//   lcd_rst_n  out  1  panel hardware reset, active-low
//   lcd_cs_n   out  1  panel chip select, active-low
//   lcd_dcx    out  1  0 = command, 1 = parameter
//   lcd_wr_n   out  1  write strobe, panel latches on the rising edge
//   lcd_db     out  8  data bus
//   busy       out  1  sequence in progress
//   done       out  1  sequence complete, held until next start or reset
// ---------------------------------------------------------------------------
module lcd_init_ctrl #(
    parameter logic [15:0] RST_LOW_CYC     = 16'd1000,
    parameter logic [23:0] RST_WAIT_CYC    = 24'd6000000,
    parameter logic [23:0] SLPOUT_WAIT_CYC = 24'd6000000,
    parameter logic [6:0]  SLPOUT_ADDR     = 7'd89,
    parameter logic [6:0]  LAST_ADDR       = 7'd103,
    parameter logic [3:0]  WR_LOW_CYC      = 4'd2,
    parameter logic [3:0]  WR_HIGH_CYC     = 4'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [6:0] rom_addr,
    input  logic [8:0] rom_data,
    output logic       lcd_rst_n,
    output logic       lcd_cs_n,
    output logic       lcd_dcx,
    output logic       lcd_wr_n,
    output logic [7:0] lcd_db,
    output logic       busy,
    output logic       done
);

    // One counter is shared by every timed state; it is as wide as the
    // widest delay parameter.
    localparam int CW = 24;

    // Terminal count of each timed state. A zero parameter behaves as 1 cycle,
    // so the terminal count never underflows.
    localparam logic [CW-1:0] RST_LOW_END =
        (RST_LOW_CYC == 16'd0) ? '0 : CW'(RST_LOW_CYC) - CW'(1);
    localparam logic [CW-1:0] RST_WAIT_END =
        (RST_WAIT_CYC == 24'd0) ? '0 : RST_WAIT_CYC - CW'(1);
    localparam logic [CW-1:0] SLPOUT_END =
        (SLPOUT_WAIT_CYC == 24'd0) ? '0 : SLPOUT_WAIT_CYC - CW'(1);
    localparam logic [CW-1:0] WR_LO_END =
        (WR_LOW_CYC == 4'd0) ? '0 : CW'(WR_LOW_CYC) - CW'(1);
    localparam logic [CW-1:0] WR_HI_END =
        (WR_HIGH_CYC == 4'd0) ? '0 : CW'(WR_HIGH_CYC) - CW'(1);

    typedef enum logic [3:0] {
        IDLE,
        RST_LOW,
        RST_WAIT,
        FETCH,
        LATCH,
        WR_LO,
        WR_HI,
        DELAY,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    // NOTE: every register here is state, so each is assigned with <= only;
    // mixing blocking assignments into a clocked block creates order-dependent
    // simulation that need not match the synthesised flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Synchronous reset aborts any state immediately, including a
            // write in progress: wr_n returns high with cs_n released, so the
            // aborted word is never a valid panel write.
            state     <= IDLE;
            cnt       <= '0;
            rom_addr  <= '0;
            lcd_rst_n <= 1'b1;
            lcd_cs_n  <= 1'b1;
            lcd_dcx   <= 1'b1;
            lcd_wr_n  <= 1'b1;
            lcd_db    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RST_LOW;
                        cnt       <= '0;
                        rom_addr  <= '0;
                        lcd_rst_n <= 1'b0;
                        lcd_cs_n  <= 1'b1;
                        lcd_wr_n  <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end

                RST_LOW: begin
                    if (cnt == RST_LOW_END) begin
                        state     <= RST_WAIT;
                        cnt       <= '0;
                        lcd_rst_n <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                RST_WAIT: begin
                    if (cnt == RST_WAIT_END) begin
                        state    <= FETCH;
                        cnt      <= '0;
                        lcd_cs_n <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // rom_addr is already stable here; the ROM registers the word
                // at the end of this cycle.
                FETCH: begin
                    state <= LATCH;
                    cnt   <= '0;
                end

                // Bus data and the falling strobe launch together, so data is
                // stable for the whole low and high phases.
                LATCH: begin
                    state    <= WR_LO;
                    cnt      <= '0;
                    lcd_dcx  <= rom_data[8];
                    lcd_db   <= rom_data[7:0];
                    lcd_wr_n <= 1'b0;
                end

                WR_LO: begin
                    if (cnt == WR_LO_END) begin
                        state    <= WR_HI;
                        cnt      <= '0;
                        lcd_wr_n <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                WR_HI: begin
                    if (cnt == WR_HI_END) begin
                        cnt <= '0;
                        if (rom_addr == SLPOUT_ADDR) begin
                            state <= DELAY;
                        end else if (rom_addr == LAST_ADDR) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            rom_addr <= rom_addr + 7'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // Only reached from the sleep-out word; if that word is also
                // the last one the sequence ends here instead of fetching.
                DELAY: begin
                    if (cnt == SLPOUT_END) begin
                        cnt <= '0;
                        if (rom_addr == LAST_ADDR) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            rom_addr <= rom_addr + 7'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_init_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_init_ctrl
//
// Directed bench for lcd_init_ctrl with short test delays. A local ROM model
// supplies the init words; a negedge monitor records every write strobe,
// the reset pulse width and the strobe timing, and checks that the bus holds
// still while the strobe is low and on its rising edge.
// ---------------------------------------------------------------------------
module tb_lcd_init_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] rom_addr;
    logic [8:0] rom_data;
    logic       lcd_rst_n;
    logic       lcd_cs_n;
    logic       lcd_dcx;
    logic       lcd_wr_n;
    logic [7:0] lcd_db;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    lcd_init_ctrl #(
        .RST_LOW_CYC    (16'd4),
        .RST_WAIT_CYC   (24'd5),
        .SLPOUT_WAIT_CYC(24'd7),
        .SLPOUT_ADDR    (7'd89),
        .LAST_ADDR      (7'd103),
        .WR_LOW_CYC     (4'd2),
        .WR_HIGH_CYC    (4'd2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .lcd_rst_n(lcd_rst_n),
        .lcd_cs_n (lcd_cs_n),
        .lcd_dcx  (lcd_dcx),
        .lcd_wr_n (lcd_wr_n),
        .lcd_db   (lcd_db),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Init ROM contents: fixed words at the addresses the sequence cares
    // about, an arbitrary but distinct pattern everywhere else.
    function automatic logic [8:0] rom_word(input int a);
        case (a)
            0:       rom_word = 9'h0F9;
            89:      rom_word = 9'h011;
            90:      rom_word = 9'h029;
            103:     rom_word = 9'h02C;
            default: rom_word = {a[0], 8'(a * 5 + 3)};
        endcase
    endfunction

    always @(posedge clk) rom_data <= rom_word(int'(rom_addr));

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic       rst_q;
    int         cyc = 0;
    int         n_rise = 0;
    int         n_fall = 0;
    int         n_rst_low = 0;
    int         rel_cyc = 0;
    int         rise_cyc [512];
    int         fall_cyc [512];
    logic [8:0] cap [512];
    logic       prev_wr;
    logic       prev_rst;
    logic [8:0] prev_bus;

    always @(posedge clk) rst_q <= rst_n;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_q === 1'b1) begin
            if (prev_wr === 1'b0)
                check("bus_stable", {23'd0, lcd_dcx, lcd_db}, {23'd0, prev_bus});
            if (prev_wr === 1'b1 && lcd_wr_n === 1'b0 && n_fall < 512) begin
                fall_cyc[n_fall] <= cyc;
                n_fall           <= n_fall + 1;
            end
            if (prev_wr === 1'b0 && lcd_wr_n === 1'b1 && n_rise < 512) begin
                rise_cyc[n_rise] <= cyc;
                cap[n_rise]      <= {lcd_dcx, lcd_db};
                n_rise           <= n_rise + 1;
            end
            if (lcd_rst_n === 1'b0) n_rst_low <= n_rst_low + 1;
            if (prev_rst === 1'b0 && lcd_rst_n === 1'b1) rel_cyc <= cyc;
        end
        prev_wr  <= lcd_wr_n;
        prev_rst <= lcd_rst_n;
        prev_bus <= {lcd_dcx, lcd_db};
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc && done !== 1'b1; i++) @(negedge clk);
        check("done_wait", {31'd0, done}, 32'd1);
    endtask

    int b1, f1, b2, rl1, rl2, b3;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_rom_addr",  {25'd0, rom_addr}, 32'd0);
        check("rst_lcd_rst_n", {31'd0, lcd_rst_n}, 32'd1);
        check("rst_cs_n",      {31'd0, lcd_cs_n}, 32'd1);
        check("rst_dcx",       {31'd0, lcd_dcx}, 32'd1);
        check("rst_wr_n",      {31'd0, lcd_wr_n}, 32'd1);
        check("rst_db",        {24'd0, lcd_db}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_done",      {31'd0, done}, 32'd0);

        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---- Run 1: full sequence with an ignored start at addr 40 ----
        b1  = n_rise;
        f1  = n_fall;
        rl1 = n_rst_low;
        pulse_start();
        check("r1_busy_after_start", {31'd0, busy}, 32'd1);
        check("r1_lcd_rst_low",      {31'd0, lcd_rst_n}, 32'd0);

        for (int i = 0; i < 2000 && rom_addr !== 7'd40; i++) @(negedge clk);
        check("r1_reach_addr40", {25'd0, rom_addr}, 32'd40);
        check("r1_busy_mid",     {31'd0, busy}, 32'd1);
        pulse_start();

        wait_done(3000);
        check("r1_busy_at_done", {31'd0, busy}, 32'd0);
        check("r1_cs_n_at_done", {31'd0, lcd_cs_n}, 32'd0);
        @(negedge clk);
        check("r1_strobes",    n_rise - b1, 32'd104);
        check("r1_falls",      n_fall - f1, 32'd104);
        check("r1_first_word", {23'd0, cap[b1]}, 32'h0F9);
        check("r1_last_word",  {23'd0, cap[b1 + 103]}, 32'h02C);
        for (int k = 0; k < 104; k++)
            check($sformatf("r1_word%0d", k), {23'd0, cap[b1 + k]},
                  {23'd0, rom_word(k)});
        check("r1_rst_low_cycles", n_rst_low - rl1, 32'd4);
        // 5 wait cycles after release, then FETCH and LATCH.
        check("r1_release_to_wr", fall_cyc[f1] - rel_cyc, 32'd7);
        // Normal gap: 2 high + FETCH + LATCH. After sleep-out: plus 7 delay.
        check("r1_gap_addr88", fall_cyc[f1 + 89] - rise_cyc[b1 + 88], 32'd4);
        check("r1_gap_addr89", fall_cyc[f1 + 90] - rise_cyc[b1 + 89], 32'd11);
        check("r1_word90",     {23'd0, cap[b1 + 90]}, 32'h029);
        check("r1_done_held",  {31'd0, done}, 32'd1);

        // ---- Run 2: start from DONE reruns the sequence ----
        b2  = n_rise;
        rl2 = n_rst_low;
        pulse_start();
        check("r2_done_cleared", {31'd0, done}, 32'd0);
        check("r2_busy",         {31'd0, busy}, 32'd1);
        check("r2_rom_addr",     {25'd0, rom_addr}, 32'd0);
        wait_done(3000);
        @(negedge clk);
        check("r2_strobes",       n_rise - b2, 32'd104);
        check("r2_last_word",     {23'd0, cap[b2 + 103]}, 32'h02C);
        check("r2_rst_low_cycles", n_rst_low - rl2, 32'd4);

        // ---- Run 3: reset during WR_LO of addr 50 ----
        b3 = n_rise;
        pulse_start();
        for (int i = 0; i < 2000 && !(rom_addr === 7'd50 && lcd_wr_n === 1'b0); i++)
            @(negedge clk);
        check("r3_reach_wr50", {24'd0, rom_addr, lcd_wr_n}, {24'd0, 7'd50, 1'b0});
        rst_n = 1'b0;
        @(negedge clk);
        check("r3_wr_n",     {31'd0, lcd_wr_n}, 32'd1);
        check("r3_cs_n",     {31'd0, lcd_cs_n}, 32'd1);
        check("r3_rom_addr", {25'd0, rom_addr}, 32'd0);
        check("r3_busy",     {31'd0, busy}, 32'd0);
        check("r3_done",     {31'd0, done}, 32'd0);
        check("r3_lcd_rst_n", {31'd0, lcd_rst_n}, 32'd1);
        check("r3_db",       {23'd0, lcd_dcx, lcd_db}, 32'h100);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("r3_strobes",   n_rise - b3, 32'd50);
        check("r3_idle_busy", {31'd0, busy}, 32'd0);
        check("r3_idle_wr_n", {31'd0, lcd_wr_n}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_init_ctrl.md
LCD_INIT_CTRL -- requirements
Module: lcd_init_ctrl

Interface
REQ-001 Parameter RST_LOW_CYC, default 16'd1000: number of cycles lcd_rst_n is held low for the panel hardware reset.
REQ-002 Parameter RST_WAIT_CYC, default 24'd6000000: number of cycles to wait after lcd_rst_n is released.
REQ-003 Parameter SLPOUT_WAIT_CYC, default 24'd6000000: delay in cycles inserted after the sleep-out entry.
REQ-004 Parameter SLPOUT_ADDR, default 7'd89: ROM address of the sleep-out command (0x11).
REQ-005 Parameter LAST_ADDR, default 7'd103: last ROM address, the memory-write command (0x2C).
REQ-006 Parameter WR_LOW_CYC, default 4'd2: number of cycles lcd_wr_n is held low per bus write.
REQ-007 Parameter WR_HIGH_CYC, default 4'd2: number of cycles lcd_wr_n is held high per bus write.
REQ-008 clk  in  1  single clock; all logic on posedge.
REQ-009 rst_n  in  1  reset, synchronous, active-low.
REQ-010 start  in  1  single-cycle pulse that launches the init sequence.
REQ-011 rom_addr  out  7  address into the init ROM.
REQ-012 rom_data  in  9  {DCX, DATA} word from the ROM, valid one cycle after rom_addr is presented.
REQ-013 lcd_rst_n  out  1  panel hardware reset, active-low.
REQ-014 lcd_cs_n  out  1  panel chip select, active-low.
REQ-015 lcd_dcx  out  1  0 = command, 1 = parameter.
REQ-016 lcd_wr_n  out  1  8080 write strobe; the panel latches on the rising edge.
REQ-017 lcd_db  out  8  8080 data bus.
REQ-018 busy  out  1  high from the cycle after start is accepted until the cycle done rises.
REQ-019 done  out  1  sequence complete; stays high until the next accepted start or reset.

Function
REQ-020 The state machine SHALL have these states: IDLE, RST_LOW, RST_WAIT, FETCH, LATCH, WR_LO, WR_HI, DELAY, DONE.
REQ-021 Transitions SHALL be:
- IDLE/DONE + start -> RST_LOW, with done cleared and rom_addr=0.
- start SHALL be ignored in every other state.
REQ-022 RST_LOW SHALL drive lcd_rst_n=0 for exactly RST_LOW_CYC cycles, then go to RST_WAIT.
REQ-023 RST_WAIT SHALL drive lcd_rst_n=1 for RST_WAIT_CYC cycles, then go to FETCH.
REQ-024 In FETCH (1 cycle), rom_addr SHALL be stable; the next state is LATCH.
REQ-025 In LATCH (1 cycle), rom_data SHALL be registered: bit 8 into lcd_dcx and [7:0] into lcd_db; the next state is WR_LO.
REQ-026 WR_LO SHALL drive lcd_wr_n=0 for WR_LOW_CYC cycles, then go to WR_HI.
- WR_HI SHALL drive lcd_wr_n=1 for WR_HIGH_CYC cycles.
- lcd_dcx and lcd_db SHALL stay stable from LATCH through the end of WR_HI.
REQ-027 On leaving WR_HI, the next state SHALL be:
- DELAY if rom_addr==SLPOUT_ADDR.
- Otherwise DONE if rom_addr==LAST_ADDR.
- Otherwise FETCH, with rom_addr incremented by 1.
REQ-028 DELAY SHALL last SLPOUT_WAIT_CYC cycles, then go to FETCH with rom_addr+1.
- If SLPOUT_ADDR==LAST_ADDR, DELAY SHALL go to DONE instead.
REQ-029 lcd_cs_n SHALL be 0 from entry to FETCH at addr 0 onward, and SHALL remain 0 in DONE so the pixel path can continue after 0x2C.
REQ-030 done SHALL assert on the first cycle in DONE.
REQ-031 Exactly LAST_ADDR+1 write strobes SHALL occur per sequence.
REQ-032 A zero-value cycle parameter SHALL be treated as 1 cycle.
REQ-033 Delay counters SHALL be sized to their parameters.
- A single shared counter is permitted.
- Counters SHALL clear on every state entry.
REQ-034 rom_addr SHALL never exceed LAST_ADDR, and SHALL not wrap.

Reset
REQ-035 While rst_n=0 at a posedge, the block SHALL go to IDLE with these output values:
- rom_addr=0, lcd_rst_n=1, lcd_cs_n=1, lcd_dcx=1, lcd_wr_n=1, lcd_db=0, busy=0, done=0.
- All counters SHALL be cleared.
REQ-036 Reset asserted mid-sequence (any state) SHALL abort at the next posedge with the REQ-035 values.
- No partial write strobe SHALL be completed.
- A fresh start SHALL be required to run again.

Verification
REQ-037 Full run (test params RST_LOW_CYC=4, RST_WAIT_CYC=5, SLPOUT_WAIT_CYC=7, WR 2/2), ROM model included, 1 start pulse:
- 104 wr_n rising edges occur.
- Captured sequence matches ROM addresses 0..103: first {0,F9}, last {0,2C}.
- done=1, lcd_cs_n=0.
REQ-038 Reset timing:
- After start, lcd_rst_n low for exactly 4 cycles.
- The first wr_n falling edge occurs no earlier than 5 cycles after release, plus 2 (FETCH/LATCH).
REQ-039 Sleep-out delay:
- The wr_n rise for addr 89 (0x11) is followed by exactly 7 idle cycles, plus FETCH and LATCH.
- Then comes the write of addr 90 (0x29).
REQ-040 Start while busy: a pulse at addr 40 leaves the sequence unchanged, still 104 strobes in total; a start in DONE clears done and reruns the full sequence.
REQ-041 Mid-run reset: rst_n=0 for 1 cycle during WR_LO at addr 50 gives next cycle outputs lcd_wr_n=1, lcd_cs_n=1, rom_addr=0, busy=0, and no further strobes.
REQ-042 Data stability: an assertion checks that lcd_db and lcd_dcx never change while lcd_wr_n=0, or within the cycle of the rising edge.
